dmem_io: RTL and testbench

Parametrised data memory with memory-mapped I/O for the PMIPS processors. Replaces the fixed two-switch, single-display data memory device: generalises data width, memory depth, switch count and display count, and adds input debouncing, edge capture with interrupt, and a free-running tick counter. Sits on the processor's data-memory port; read data is combinational so single-cycle cores keep working unchanged.

---
 rtl/dmem_io_pkg.sv | 21 ++
 rtl/io_debounce.sv | 51 +++++
 rtl/dmem_io.sv | 135 +++++++++++++
 tb/tb_dmem_io.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_io_pkg.sv
// rtl/dmem_io_pkg.sv - shared constants and types for the dmem_io data memory
package dmem_io_pkg;

  // Byte span of the memory-mapped I/O block starting at IO_BASE.
  localparam int IO_SPAN = 32;

  // Byte offsets of the I/O registers within the block.
  localparam logic [4:0] OFF_SW   = 5'h00;
  localparam logic [4:0] OFF_EDGE = 5'h02;
  localparam logic [4:0] OFF_TICK = 5'h04;
  localparam logic [4:0] OFF_IE   = 5'h06;
  localparam logic [4:0] OFF_OUT  = 5'h08;

  // Which part of the address space the current access falls into.
  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_IO
  } region_e;

endpackage

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - two-flop synchroniser plus debounce counter for one switch
module io_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o
);

  // Counter only needs to reach DEBOUNCE_CYC-1; the final mismatching cycle flips the level.
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done;

  assign done = (cnt_q == CW'(DEBOUNCE_CYC - 1));

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (done) level_d = sync2_q;
      else      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Synchroniser, counter and debounced level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  // Rising edge is flagged on the same clock edge that the level goes high.
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/dmem_io.sv
// rtl/dmem_io.sv - data memory with memory-mapped switches, displays, tick and irq
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int                DATA_W       = 16,
  parameter int                MEM_DEPTH    = 128,
  parameter int                NUM_IN       = 2,
  parameter int                NUM_OUT      = 1,
  parameter int                OUT_W        = 7,
  parameter logic [OUT_W-1:0]  OUT_RESET    = 7'h7F,
  parameter logic [DATA_W-1:0] IO_BASE      = 16'hFFE0,
  parameter int                DEBOUNCE_CYC = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     write_i,
  input  logic                     read_i,
  output logic [DATA_W-1:0]        rdata_o,
  input  logic [NUM_IN-1:0]        sw_i,
  output logic [NUM_OUT*OUT_W-1:0] io_out_o,
  output logic                     irq_o
);

  localparam int AW = $clog2(MEM_DEPTH);
  // One extra bit so IO_BASE+IO_SPAN cannot wrap at the top of the address space.
  localparam logic [DATA_W:0] RAM_END = (DATA_W + 1)'(2 * MEM_DEPTH);
  localparam logic [DATA_W:0] IO_LO   = {1'b0, IO_BASE};
  localparam logic [DATA_W:0] IO_HI   = IO_LO + (DATA_W + 1)'(IO_SPAN);

  logic [DATA_W-1:0] ram_q [MEM_DEPTH];

  logic [NUM_IN-1:0] sw_lvl, sw_rise;
  logic [NUM_IN-1:0] edge_q, edge_d, ie_q, ie_d;
  logic [DATA_W-1:0] tick_q, tick_d;
  logic              irq_q, irq_d;

  region_e           rgn;
  logic [DATA_W:0]   addr_ext;
  logic [4:0]        off;
  logic [AW-1:0]     ram_idx;
  logic              io_wr;
  logic [DATA_W-1:0] rd_val;

  assign addr_ext = {1'b0, addr_i};
  assign off      = {addr_i[4:1], 1'b0};
  assign ram_idx  = addr_i[AW:1];
  assign io_wr    = write_i && (rgn == RGN_IO);

  // Classify the access as RAM, I/O or unmapped.
  always_comb begin
    rgn = RGN_NONE;
    if (addr_ext < RAM_END)                        rgn = RGN_RAM;
    else if (addr_ext >= IO_LO && addr_ext < IO_HI) rgn = RGN_IO;
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sw_i   (sw_i[i]),
      .level_o(sw_lvl[i]),
      .rise_o (sw_rise[i])
    );
  end

  // Next-state for I/O registers; a new edge overrides a same-cycle W1C clear.
  always_comb begin
    edge_d = edge_q & ~((io_wr && off == OFF_EDGE) ? wdata_i[NUM_IN-1:0] : '0);
    edge_d = edge_d | sw_rise;
    ie_d   = (io_wr && off == OFF_IE) ? wdata_i[NUM_IN-1:0] : ie_q;
    tick_d = (io_wr && off == OFF_TICK) ? wdata_i : tick_q + DATA_W'(1);
    irq_d  = |(edge_q & ie_q);
  end

  // I/O state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edge_q <= '0;
      ie_q   <= '0;
      tick_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      ie_q   <= ie_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (write_i && rgn == RGN_RAM) ram_q[ram_idx] <= wdata_i;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    logic             we;
    logic [OUT_W-1:0] out_q;

    assign we = io_wr && (off == OFF_OUT + 5'(2 * k));

    // Display register k keeps only the low OUT_W bits of a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)  out_q <= OUT_RESET;
      else if (we)  out_q <= wdata_i[OUT_W-1:0];
    end

    assign io_out_o[k*OUT_W +: OUT_W] = out_q;
  end

  // Combinational read mux; unmapped locations and unused bits read as zero.
  always_comb begin
    rd_val = '0;
    case (rgn)
      RGN_RAM: rd_val = ram_q[ram_idx];
      RGN_IO: begin
        if (off == OFF_SW)        rd_val[NUM_IN-1:0] = sw_lvl;
        else if (off == OFF_EDGE) rd_val[NUM_IN-1:0] = edge_q;
        else if (off == OFF_TICK) rd_val             = tick_q;
        else if (off == OFF_IE)   rd_val[NUM_IN-1:0] = ie_q;
        else begin
          for (int k = 0; k < NUM_OUT; k++) begin
            if (off == OFF_OUT + 5'(2 * k)) rd_val[OUT_W-1:0] = io_out_o[k*OUT_W +: OUT_W];
          end
        end
      end
      default: rd_val = '0;
    endcase
  end

  assign rdata_o = read_i ? rd_val : '0;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_dmem_io.sv
// tb/tb_dmem_io.sv - directed self-checking bench for dmem_io
module tb_dmem_io;

  localparam logic [15:0] IOB    = 16'hFFE0;
  localparam logic [15:0] A_SW   = IOB + 16'h0;
  localparam logic [15:0] A_EDGE = IOB + 16'h2;
  localparam logic [15:0] A_TICK = IOB + 16'h4;
  localparam logic [15:0] A_IE   = IOB + 16'h6;
  localparam logic [15:0] A_OUT0 = IOB + 16'h8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wdata, rdata;
  logic        write, read;
  logic [1:0]  sw;
  logic [6:0]  io_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  dmem_io dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .addr_i  (addr),
    .wdata_i (wdata),
    .write_i (write),
    .read_i  (read),
    .rdata_o (rdata),
    .sw_i    (sw),
    .io_out_o(io_out),
    .irq_o   (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr  = a;
    read  = 1'b1;
    write = 1'b0;
    #1;
    check(tag, rdata, exp);
    read = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    write = 1'b1;
    read  = 1'b0;
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; write = 1'b0; read = 1'b0; sw = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_io_out", io_out, 7'h7F);
    check("rst_irq", irq, 1'b0);

    rst_n = 1'b1;
    rdchk("rst_out0", A_OUT0, 16'h007F);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rdchk("tick_after_rst", A_TICK, 16'h0002);

    // RAM and unmapped region
    wr(16'h0000, 16'h5555);
    wr(16'h0010, 16'h1234);
    rdchk("ram_0010", 16'h0010, 16'h1234);
    addr = 16'h0010; read = 1'b0; #1;
    check("read_low_zero", rdata, 16'h0000);
    rdchk("hole_0200", 16'h0200, 16'h0000);
    @(negedge clk);
    wr(16'h0200, 16'hABCD);
    rdchk("hole_0200_wr", 16'h0200, 16'h0000);
    rdchk("no_alias_0000", 16'h0000, 16'h5555);

    // IE upper bits read as zero
    @(negedge clk);
    wr(A_IE, 16'hFFFF);
    rdchk("ie_mask", A_IE, 16'h0003);

    // short glitch on sw[0] must be filtered
    @(negedge clk);
    sw = 2'b01;
    repeat (3) @(negedge clk);
    sw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("glitch_irq", irq, 1'b0);
    end
    rdchk("glitch_sw", A_SW, 16'h0000);
    rdchk("glitch_edge", A_EDGE, 16'h0000);

    // sw[1] rising: visible exactly 6 edges later, irq one edge after that
    @(negedge clk);
    sw = 2'b10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rdchk("sw_at5", A_SW, 16'h0000);
    @(negedge clk);
    rdchk("sw_at6", A_SW, 16'h0002);
    rdchk("edge_at6", A_EDGE, 16'h0002);
    check("irq_at6", irq, 1'b0);
    @(negedge clk);
    check("irq_at7", irq, 1'b1);

    // set wins over same-cycle W1C
    sw = 2'b00;
    repeat (8) @(negedge clk);
    rdchk("fall_sw", A_SW, 16'h0000);
    rdchk("fall_edge_kept", A_EDGE, 16'h0002);
    @(negedge clk);
    sw = 2'b10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    wr(A_EDGE, 16'h0002);
    rdchk("set_wins_edge", A_EDGE, 16'h0002);
    rdchk("set_wins_sw", A_SW, 16'h0002);
    @(negedge clk);
    wr(A_EDGE, 16'h0002);
    rdchk("w1c_edge", A_EDGE, 16'h0000);
    check("w1c_irq_hold", irq, 1'b1);
    @(negedge clk);
    check("w1c_irq_fall", irq, 1'b0);

    // display register
    wr(A_OUT0, 16'hFF92);
    check("out0_io", io_out, 7'h12);
    rdchk("out0_rd", A_OUT0, 16'h0012);
    rdchk("out0_odd_addr", IOB + 16'h9, 16'h0012);
    rdchk("unused_0a", IOB + 16'hA, 16'h0000);
    rdchk("unused_1e", IOB + 16'h1E, 16'h0000);

    // tick wrap
    @(negedge clk);
    wr(A_TICK, 16'hFFFF);
    rdchk("tick_load", A_TICK, 16'hFFFF);
    @(negedge clk);
    rdchk("tick_wrap", A_TICK, 16'h0000);

    // reset in the middle of debouncing
    @(negedge clk);
    sw = 2'b01;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check("arst_io_out", io_out, 7'h7F);
    rdchk("arst_sw", A_SW, 16'h0000);
    rdchk("arst_edge", A_EDGE, 16'h0000);
    rdchk("arst_tick", A_TICK, 16'h0000);
    check("arst_irq", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rdchk("post_rst_sw5", A_SW, 16'h0000);
    @(negedge clk);
    rdchk("post_rst_sw6", A_SW, 16'h0001);
    rdchk("post_rst_edge", A_EDGE, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
